// File: rtl/api_slave_pkg.sv
// Shared constants and FSM encoding for the api serial-link slave.
package api_define;
    localparam int API_WORD_W = 32;
    localparam logic [API_WORD_W-1:0] API_IDLE_PAT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_END   = 2'd3
    } api_state_e;
endpackage

// File: rtl/api_slave_if.sv
// Serial link plus parallel rx/tx/frame signals of the api slave.
interface api_slave_if #(
    parameter int WORD_CNT_W = 8,
    parameter int TX_DEPTH   = 16
);
    import api_define::*;
    localparam int CNT_W = $clog2(TX_DEPTH) + 1;

    logic                  sck;
    logic                  mosi;
    logic                  load;
    logic                  miso;
    logic                  rx_vld;
    logic [API_WORD_W-1:0] rx_dat;
    logic [WORD_CNT_W-1:0] rx_idx;
    logic                  frame_done;
    logic [WORD_CNT_W-1:0] frame_words;
    logic                  frame_err;
    logic                  tx_wr_en;
    logic [API_WORD_W-1:0] tx_din;
    logic                  tx_full;
    logic [CNT_W-1:0]      tx_cnt;
    logic                  underrun;

    modport master (
        output sck, mosi, load, tx_wr_en, tx_din,
        input  miso, rx_vld, rx_dat, rx_idx, frame_done, frame_words, frame_err,
               tx_full, tx_cnt, underrun
    );

    modport slave (
        input  sck, mosi, load, tx_wr_en, tx_din,
        output miso, rx_vld, rx_dat, rx_idx, frame_done, frame_words, frame_err,
               tx_full, tx_cnt, underrun
    );
endinterface

// File: rtl/api_slave_fifo.sv
// Single-clock first-word-fall-through FIFO holding reply words.
module api_slave_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   cnt_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             wr_ok, rd_ok;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A pop frees the slot a simultaneous push into a full FIFO needs.
    assign rd_ok = rd_en_i && !empty_o;
    assign wr_ok = wr_en_i && (!full_o || rd_en_i);

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/api_slave.sv
// api link target: oversamples sck/mosi/load, deserialises 32-bit words
// from mosi and shifts queued reply words onto miso.
module api_slave
    import api_define::*;
#(
    parameter int                    SYNC_STAGES = 2,
    parameter int                    TX_DEPTH    = 16,
    parameter logic [API_WORD_W-1:0] IDLE_PAT    = API_IDLE_PAT,
    parameter int                    WORD_CNT_W  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    api_slave_if.slave bus
);
    localparam int CNT_W = $clog2(TX_DEPTH) + 1;
    localparam int BIT_W = $clog2(API_WORD_W);

    function automatic logic [WORD_CNT_W-1:0] sat_inc(input logic [WORD_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, load_sync_q;
    logic                   sck_prev_q, load_prev_q;
    logic                   sck_s, mosi_s, load_s;
    logic                   sck_rise, sck_fall, load_rise, load_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            load_sync_q <= '1;
            sck_prev_q  <= 1'b0;
            load_prev_q <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
            load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], bus.load};
            sck_prev_q  <= sck_s;
            load_prev_q <= load_s;
        end
    end

    assign sck_s     = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign load_s    = load_sync_q[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_prev_q;
    assign sck_fall  = ~sck_s & sck_prev_q;
    assign load_rise = load_s & ~load_prev_q;
    assign load_fall = ~load_s & load_prev_q;

    logic                  fifo_rd, fifo_empty, tx_full;
    logic [API_WORD_W-1:0] fifo_head, next_word;
    logic [CNT_W-1:0]      tx_cnt;

    api_slave_fifo #(.DEPTH(TX_DEPTH), .WIDTH(API_WORD_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en_i (bus.tx_wr_en),
        .din_i   (bus.tx_din),
        .rd_en_i (fifo_rd),
        .dout_o  (fifo_head),
        .full_o  (tx_full),
        .empty_o (fifo_empty),
        .cnt_o   (tx_cnt)
    );

    assign next_word = fifo_empty ? IDLE_PAT : fifo_head;

    api_state_e            state_q, state_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [API_WORD_W-2:0] rx_shift_q, rx_shift_d;
    // miso_q is the reply MSB; tx_shift holds the 31 bits still to go.
    logic [API_WORD_W-2:0] tx_shift_q, tx_shift_d;
    logic                  miso_q, miso_d;
    logic                  rx_vld_q, rx_vld_d;
    logic [API_WORD_W-1:0] rx_dat_q, rx_dat_d;
    logic [WORD_CNT_W-1:0] rx_idx_q, rx_idx_d;
    logic                  frame_done_q, frame_done_d;
    logic [WORD_CNT_W-1:0] frame_words_q, frame_words_d;
    logic                  frame_err_q, frame_err_d;
    logic                  underrun_q, underrun_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            word_cnt_q    <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            miso_q        <= 1'b1;
            rx_vld_q      <= 1'b0;
            rx_dat_q      <= '0;
            rx_idx_q      <= '0;
            frame_done_q  <= 1'b0;
            frame_words_q <= '0;
            frame_err_q   <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            word_cnt_q    <= word_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            miso_q        <= miso_d;
            rx_vld_q      <= rx_vld_d;
            rx_dat_q      <= rx_dat_d;
            rx_idx_q      <= rx_idx_d;
            frame_done_q  <= frame_done_d;
            frame_words_q <= frame_words_d;
            frame_err_q   <= frame_err_d;
            underrun_q    <= underrun_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        word_cnt_d    = word_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        miso_d        = miso_q;
        rx_dat_d      = rx_dat_q;
        rx_idx_d      = rx_idx_q;
        frame_words_d = frame_words_q;
        underrun_d    = underrun_q;
        rx_vld_d      = 1'b0;
        frame_done_d  = 1'b0;
        frame_err_d   = 1'b0;
        fifo_rd       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b1;
                if (load_fall) state_d = ST_ARM;
            end
            ST_ARM: begin
                fifo_rd    = 1'b1;
                miso_d     = next_word[API_WORD_W-1];
                tx_shift_d = next_word[API_WORD_W-2:0];
                underrun_d = underrun_q | fifo_empty;
                bit_cnt_d  = '0;
                word_cnt_d = '0;
                state_d    = load_rise ? ST_END : ST_SHIFT;
            end
            ST_SHIFT: begin
                // Deselect wins over a coincident sck edge.
                if (load_rise) begin
                    state_d = ST_END;
                end else if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[API_WORD_W-3:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_W'(API_WORD_W-1)) begin
                        rx_vld_d   = 1'b1;
                        rx_dat_d   = {rx_shift_q, mosi_s};
                        rx_idx_d   = word_cnt_q;
                        word_cnt_d = sat_inc(word_cnt_q);
                    end
                end else if (sck_fall) begin
                    if (bit_cnt_q != '0) begin
                        miso_d     = tx_shift_q[API_WORD_W-2];
                        tx_shift_d = {tx_shift_q[API_WORD_W-3:0], 1'b0};
                    end else if (word_cnt_q != '0) begin
                        fifo_rd    = 1'b1;
                        miso_d     = next_word[API_WORD_W-1];
                        tx_shift_d = next_word[API_WORD_W-2:0];
                        underrun_d = underrun_q | fifo_empty;
                    end
                end
            end
            ST_END: begin
                frame_done_d  = 1'b1;
                frame_words_d = word_cnt_q;
                frame_err_d   = (bit_cnt_q != '0);
                miso_d        = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.miso        = miso_q;
    assign bus.rx_vld      = rx_vld_q;
    assign bus.rx_dat      = rx_dat_q;
    assign bus.rx_idx      = rx_idx_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_words = frame_words_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.tx_full     = tx_full;
    assign bus.tx_cnt      = tx_cnt;
    assign bus.underrun    = underrun_q;
endmodule
